// File: rtl/fixed_frame_marker_if.sv
// AXI4-Stream bundle carrying the video pixel stream into and out of the marker.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 16,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1
);
  localparam int TDATA_WIDTH_B = TDATA_WIDTH / 8;

  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH_B-1:0] tstrb;
  logic [TDATA_WIDTH_B-1:0] tkeep;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic                     tuser;
  logic                     tlast;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/fixed_frame_marker.sv
// Re-tags an unmarked pixel stream with SOF (tuser) and EOL (tlast) derived from a
// fixed frame geometry, through a single output register stage.
module fixed_frame_marker #(
  parameter int FRAME_RES_X = 1920,
  parameter int FRAME_RES_Y = 1080,
  parameter int PX_WIDTH    = 10,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  axi4_stream_if.slave  video_i,
  axi4_stream_if.master video_o,
  input  logic          resync_i,
  output logic          frame_done_o
);
  localparam int TDATA_WIDTH   = ((PX_WIDTH + 7) / 8) * 8;
  localparam int TDATA_WIDTH_B = TDATA_WIDTH / 8;
  localparam int PX_W          = $clog2(FRAME_RES_X);
  localparam int LN_W          = $clog2(FRAME_RES_Y);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(FRAME_RES_X - 1);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(FRAME_RES_Y - 1);

  logic                     r_tvalid;
  logic [TDATA_WIDTH-1:0]   r_tdata;
  logic [TDATA_WIDTH_B-1:0] r_tstrb;
  logic [TDATA_WIDTH_B-1:0] r_tkeep;
  logic [TID_WIDTH-1:0]     r_tid;
  logic [TDEST_WIDTH-1:0]   r_tdest;
  logic                     r_tuser;
  logic                     r_tlast;
  logic                     r_last_px;
  logic [PX_W-1:0]          r_px_cnt;
  logic [LN_W-1:0]          r_line_cnt;

  logic            w_in_ready;
  logic            w_hs_i;
  logic [PX_W-1:0] w_px_eff;
  logic [LN_W-1:0] w_line_eff;
  logic [PX_W-1:0] w_px_next;
  logic [LN_W-1:0] w_line_next;
  logic            w_is_sof;
  logic            w_is_eol;
  logic            w_is_eof;

  assign w_in_ready = !r_tvalid || video_o.tready;
  assign w_hs_i     = video_i.tvalid && w_in_ready;

  // A resync makes the beat in the same cycle position (0,0) before any counting.
  assign w_px_eff   = resync_i ? '0 : r_px_cnt;
  assign w_line_eff = resync_i ? '0 : r_line_cnt;

  assign w_is_sof = (w_px_eff == '0) && (w_line_eff == '0);
  assign w_is_eol = (w_px_eff == PX_LAST);
  assign w_is_eof = w_is_eol && (w_line_eff == LN_LAST);

  always_comb begin
    w_px_next   = w_px_eff + PX_W'(1);
    w_line_next = w_line_eff;
    if (w_is_eol) begin
      w_px_next   = '0;
      w_line_next = (w_line_eff == LN_LAST) ? '0 : w_line_eff + LN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_tstrb    <= '0;
      r_tkeep    <= '0;
      r_tid      <= '0;
      r_tdest    <= '0;
      r_tuser    <= 1'b0;
      r_tlast    <= 1'b0;
      r_last_px  <= 1'b0;
      r_px_cnt   <= '0;
      r_line_cnt <= '0;
    end else begin
      if (w_in_ready) begin
        r_tvalid  <= video_i.tvalid;
        r_tdata   <= video_i.tdata;
        r_tstrb   <= video_i.tstrb;
        r_tkeep   <= video_i.tkeep;
        r_tid     <= video_i.tid;
        r_tdest   <= video_i.tdest;
        r_tuser   <= w_hs_i && w_is_sof;
        r_tlast   <= w_hs_i && w_is_eol;
        r_last_px <= w_hs_i && w_is_eof;
      end
      if (w_hs_i) begin
        r_px_cnt   <= w_px_next;
        r_line_cnt <= w_line_next;
      end else if (resync_i) begin
        r_px_cnt   <= '0;
        r_line_cnt <= '0;
      end
    end
  end

  assign video_i.tready = w_in_ready;
  assign video_o.tvalid = r_tvalid;
  assign video_o.tdata  = r_tdata;
  assign video_o.tstrb  = r_tstrb;
  assign video_o.tkeep  = r_tkeep;
  assign video_o.tid    = r_tid;
  assign video_o.tdest  = r_tdest;
  assign video_o.tuser  = r_tuser;
  assign video_o.tlast  = r_tlast;

  assign frame_done_o = r_tvalid && video_o.tready && r_tlast && r_last_px;
endmodule

// File: tb/tb_fixed_frame_marker.sv
// Self-checking bench for fixed_frame_marker on a 4x3 frame: a position-in-frame
// scoreboard predicts markers, plus literal marker masks for directed scenarios.
module tb_fixed_frame_marker;
  localparam int RES_X = 4;
  localparam int RES_Y = 3;
  localparam int FRAME = RES_X * RES_Y;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  strb;
    logic [1:0]  keep;
    logic        id;
    logic        dest;
    bit          sof;
    bit          eol;
    bit          eof;
  } beat_t;

  logic clk;
  logic rstN;
  logic resync;
  logic frameDone;

  axi4_stream_if #(.TDATA_WIDTH(16)) vin ();
  axi4_stream_if #(.TDATA_WIDTH(16)) vout ();

  fixed_frame_marker #(
    .FRAME_RES_X(RES_X),
    .FRAME_RES_Y(RES_Y),
    .PX_WIDTH(10),
    .TID_WIDTH(1),
    .TDEST_WIDTH(1)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rstN),
    .video_i(vin),
    .video_o(vout),
    .resync_i(resync),
    .frame_done_o(frameDone)
  );

  int          errors = 0;
  int          checks = 0;
  beat_t       expQ[$];
  int          modelPos = 0;
  int          outIdx = 0;
  logic [31:0] sofMask = '0;
  logic [31:0] eolMask = '0;
  logic [31:0] eofMask = '0;
  logic [15:0] nextData = 16'h0100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearMasks();
    outIdx  = 0;
    sofMask = '0;
    eolMask = '0;
    eofMask = '0;
  endtask

  // Reference model: each accepted input beat gets a position in the frame, from which
  // its markers follow directly; the output register holds at most one beat.
  initial begin
    beat_t e;
    bit    prevStall;
    logic [15:0] prevData;
    logic  prevUser;
    logic  prevLast;
    int    p;
    prevStall = 0;
    prevData  = '0;
    prevUser  = 0;
    prevLast  = 0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        checkOutput("reset_outputs",
                    {vout.tvalid, vout.tuser, vout.tlast, frameDone, vout.tdata,
                     vout.tstrb, vout.tkeep, vout.tid, vout.tdest}, 64'd0);
        expQ.delete();
        modelPos  = 0;
        prevStall = 0;
      end else begin
        checkOutput("tvalid", vout.tvalid, (expQ.size() != 0));
        if (prevStall)
          checkOutput("stall_hold", {vout.tdata, vout.tuser, vout.tlast},
                      {prevData, prevUser, prevLast});
        if (vout.tvalid && vout.tready && expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("tdata", vout.tdata, e.data);
          checkOutput("sideband", {vout.tstrb, vout.tkeep, vout.tid, vout.tdest},
                      {e.strb, e.keep, e.id, e.dest});
          checkOutput("tuser", vout.tuser, e.sof);
          checkOutput("tlast", vout.tlast, e.eol);
          checkOutput("frame_done", frameDone, e.eof);
          if (outIdx < 32) begin
            sofMask[outIdx] = vout.tuser;
            eolMask[outIdx] = vout.tlast;
            eofMask[outIdx] = frameDone;
          end
          outIdx++;
        end else begin
          checkOutput("frame_done_idle", frameDone, 1'b0);
        end
        prevStall = vout.tvalid && !vout.tready;
        prevData  = vout.tdata;
        prevUser  = vout.tuser;
        prevLast  = vout.tlast;
        if (vin.tvalid && vin.tready) begin
          p = resync ? 0 : modelPos;
          e.data = vin.tdata;
          e.strb = vin.tstrb;
          e.keep = vin.tkeep;
          e.id   = vin.tid;
          e.dest = vin.tdest;
          e.sof  = (p == 0);
          e.eol  = ((p % RES_X) == RES_X - 1);
          e.eof  = (p == FRAME - 1);
          expQ.push_back(e);
          modelPos = (p + 1) % FRAME;
        end else if (resync) begin
          modelPos = 0;
        end
      end
    end
  end

  // Streams nBeats consecutive data words; resync is raised while beat index resyncAt is offered.
  task automatic applyStimulus(input int nBeats, input bit randValid, input bit randReady,
                               input int resyncAt, input bit garbage, input bit drain);
    int  sent;
    int  cyc;
    bit  accepted;
    sent = 0;
    cyc  = 0;
    while (sent < nBeats && cyc < 2000) begin
      vin.tvalid  = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
      vin.tdata   = nextData;
      vin.tstrb   = nextData[1:0];
      vin.tkeep   = ~nextData[1:0];
      vin.tid     = nextData[2];
      vin.tdest   = nextData[3];
      vin.tuser   = garbage;
      vin.tlast   = garbage;
      resync      = (sent == resyncAt);
      vout.tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      accepted = vin.tvalid && vin.tready;
      @(posedge clk);
      #1;
      if (accepted) begin
        sent++;
        nextData++;
      end
      cyc++;
    end
    if (sent < nBeats) begin
      checks++;
      errors++;
      $display("[TB] FAIL stimulus_timeout: sent %0d beats, required %0d", sent, nBeats);
    end
    vin.tvalid = 1'b0;
    vin.tuser  = 1'b0;
    vin.tlast  = 1'b0;
    resync     = 1'b0;
    if (drain) begin
      vout.tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] heldData;
    rstN        = 1'b0;
    resync      = 1'b0;
    vin.tvalid  = 1'b0;
    vin.tdata   = '0;
    vin.tstrb   = '0;
    vin.tkeep   = '0;
    vin.tid     = 1'b0;
    vin.tdest   = 1'b0;
    vin.tuser   = 1'b0;
    vin.tlast   = 1'b0;
    vout.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutput("post_reset_done", frameDone, 1'b0);

    $display("[TB] continuous 24 beats");
    clearMasks();
    applyStimulus(24, 0, 0, -1, 0, 1);
    checkOutput("t1_beats", outIdx, 24);
    checkOutput("t1_sof_mask", sofMask, 32'h0000_1001);
    checkOutput("t1_eol_mask", eolMask, 32'h0088_8888);
    checkOutput("t1_eof_mask", eofMask, 32'h0080_0800);

    $display("[TB] input tuser/tlast forced high");
    clearMasks();
    applyStimulus(24, 0, 0, -1, 1, 1);
    checkOutput("t2_sof_mask", sofMask, 32'h0000_1001);
    checkOutput("t2_eol_mask", eolMask, 32'h0088_8888);
    checkOutput("t2_eof_mask", eofMask, 32'h0080_0800);

    $display("[TB] resync on beat 6");
    clearMasks();
    applyStimulus(18, 0, 0, 6, 0, 1);
    checkOutput("t3_sof_mask", sofMask, 32'h0000_0041);
    checkOutput("t3_eol_mask", eolMask, 32'h0002_2208);
    checkOutput("t3_eof_mask", eofMask, 32'h0002_0000);

    $display("[TB] stall on final pixel");
    applyStimulus(11, 0, 0, 0, 0, 1);
    heldData    = nextData;
    vin.tvalid  = 1'b1;
    vin.tdata   = nextData;
    vin.tstrb   = nextData[1:0];
    vin.tkeep   = ~nextData[1:0];
    vin.tid     = nextData[2];
    vin.tdest   = nextData[3];
    vout.tready = 1'b1;
    @(posedge clk);
    #1;
    nextData++;
    vin.tvalid  = 1'b0;
    vout.tready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_tlast", vout.tlast, 1'b1);
      checkOutput("stall_tdata", vout.tdata, heldData);
      checkOutput("stall_done", frameDone, 1'b0);
      @(posedge clk);
      #1;
    end
    vout.tready = 1'b1;
    @(negedge clk);
    checkOutput("stall_release_done", frameDone, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] random valid/ready over 5 frames");
    clearMasks();
    applyStimulus(60, 1, 1, 0, 1, 1);
    checkOutput("t5_beats", outIdx, 60);
    checkOutput("t5_sof_mask", sofMask, 32'h0100_1001);
    checkOutput("t5_eol_mask", eolMask, 32'h8888_8888);
    checkOutput("t5_eof_mask", eofMask, 32'h0080_0800);

    $display("[TB] reset mid-frame");
    applyStimulus(6, 0, 0, -1, 0, 0);
    rstN = 1'b0;
    #1;
    checkOutput("midreset_tvalid", vout.tvalid, 1'b0);
    checkOutput("midreset_tdata", vout.tdata, 16'h0000);
    checkOutput("midreset_markers", {vout.tuser, vout.tlast, frameDone}, 3'b000);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    clearMasks();
    applyStimulus(12, 0, 0, -1, 0, 1);
    checkOutput("t6_sof_mask", sofMask, 32'h0000_0001);
    checkOutput("t6_eol_mask", eolMask, 32'h0000_0888);
    checkOutput("t6_eof_mask", eofMask, 32'h0000_0800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fixed_frame_marker.md
FIXED_FRAME_MARKER -- requirements
Module: fixed_frame_marker

Interface
REQ-001 Parameter FRAME_RES_X, default 1920, meaning active pixels per line (≥2).
REQ-002 Parameter FRAME_RES_Y, default 1080, meaning active lines per frame (≥2).
REQ-003 Parameter PX_WIDTH, default 10, meaning pixel width; TDATA_WIDTH = PX_WIDTH rounded up to a multiple of 8, TDATA_WIDTH_B = TDATA_WIDTH/8.
REQ-004 Port clk_i, input, 1, single clock; all logic on rising edge.
REQ-005 Port rst_n_i, input, 1, reset, asynchronous and active-low.
REQ-006 Port video_i, axi4_stream_if.slave, TDATA_WIDTH, unmarked pixel stream; tuser/tlast ignored.
REQ-007 Port video_o, axi4_stream_if.master, TDATA_WIDTH, same stream with tuser/tlast regenerated from fixed resolution.
REQ-008 Port resync_i, input, 1, realign pulse: the next accepted beat is pixel 0 of line 0.
REQ-009 Port frame_done_o, output, 1, high in the cycle the frame's final pixel is accepted on video_o.

Function
REQ-010 Block SHALL hold pixel counter px_cnt, width $clog2(FRAME_RES_X), and line counter line_cnt, width $clog2(FRAME_RES_Y).
REQ-011 Input handshake hs_i = video_i.tvalid && video_i.tready; output handshake hs_o = video_o.tvalid && video_o.tready.
REQ-012 video_i.tready SHALL equal !video_o.tvalid || video_o.tready (single output register stage).
REQ-013 When video_i.tready is high, the output register SHALL load tvalid, tdata, tstrb, tkeep, tid, tdest from video_i; otherwise it holds.
REQ-014 Loaded tuser SHALL be 1 only when the beat is pixel 0 of line 0 and hs_i.
REQ-015 Loaded tlast SHALL be 1 only when the beat is pixel FRAME_RES_X-1 and hs_i.
REQ-016 A registered flag last_px SHALL be loaded high with the beat at px FRAME_RES_X-1, line FRAME_RES_Y-1.
REQ-017 frame_done_o SHALL equal hs_o && video_o.tlast && last_px, combinationally.
REQ-018 Latency SHALL be one cycle from hs_i to video_o.tvalid, with no bubbles under continuous valid/ready.
REQ-019 On hs_i without resync_i: px_cnt increments; at FRAME_RES_X-1 it wraps to 0 and line_cnt increments; at line FRAME_RES_Y-1 with wrap, line_cnt wraps to 0.
REQ-020 resync_i with hs_i in the same cycle: the beat SHALL be tagged pixel 0 of line 0 (tuser=1), then px_cnt←1, line_cnt←0.
REQ-021 resync_i without hs_i: px_cnt←0 and line_cnt←0; the output register is unaffected.
REQ-022 Input tuser/tlast values SHALL never reach video_o.
REQ-023 While the output is stalled (video_o.tvalid && !video_o.tready), the output register and counters SHALL hold; stalls SHALL cause no beat loss or duplication.
REQ-024 Counters SHALL never exceed FRAME_RES_X-1 and FRAME_RES_Y-1.

Reset
REQ-025 While rst_n_i is low, video_o.tvalid, tdata, tuser, tlast, tstrb, tkeep, tid and tdest SHALL be 0; px_cnt, line_cnt and last_px SHALL be 0.
REQ-026 After reset, frame_done_o SHALL be 0 and the first accepted beat SHALL be tagged SOF.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the next frame after release starts at pixel 0 of line 0.

Verification (FRAME_RES_X=4, FRAME_RES_Y=3, PX_WIDTH=10)
REQ-028 Continuous 24 beats, tready=1 -> tuser on beats 0 and 12; tlast on beats 3,7,11,15,19,23; frame_done_o on beats 11 and 23; one-cycle latency.
REQ-029 Random tvalid and tready over 5 frames -> output data order equals input order; markers at the same positions as REQ-028; no loss or duplication.
REQ-030 Input driving tuser=1 and tlast=1 on every beat -> output markers identical to REQ-028.
REQ-031 resync_i with hs_i on beat 6 -> that beat has tuser=1; the next tlast falls 3 beats later; frame_done_o falls 11 beats later.
REQ-032 tready=0 for 5 cycles while tlast is held on the output -> tlast and tdata stable; frame_done_o only in the handshake cycle.
REQ-033 rst_n_i low for 1 cycle after beat 5 -> all outputs 0 immediately; the first beat after release has tuser=1.
